fetch_ctrl: RTL and testbench

//  Sequencing controller for the fetch stage of the pipelined ARM core. Drives the fetch PC

---
 rtl/fetch_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fetch_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: imem req/ready/rvalid handshake, PC enable/redirect, decode-stall hold.
// Optional performance counters are compiled in when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc_E,
    input  logic [63:0] PCBranch_E,
    input  logic        stall_D,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    output logic        imem_req,
    output logic        pc_en_F,
    output logic        PCSrc_F,
    output logic [63:0] PCBranch_F,
    output logic        instr_valid_F,
    output logic        flush_D,
    output logic        imem_err,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_redir
);
    localparam int unsigned CW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

    state_e        state_q, state_d;
    logic          pending_q, pending_d;
    logic [63:0]   target_q, target_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [CW-1:0] wait_cnt_inc;
    logic          imem_err_q, imem_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_REQ;
            pending_q  <= 1'b0;
            target_q   <= '0;
            wait_cnt_q <= '0;
            imem_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            target_q   <= target_d;
            wait_cnt_q <= wait_cnt_d;
            imem_err_q <= imem_err_d;
        end
    end

    assign wait_cnt_inc = wait_cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        target_d   = target_q;
        wait_cnt_d = wait_cnt_q;
        imem_err_d = imem_err_q;
        unique case (state_q)
            S_REQ: begin
                if (!PCSrc_E && imem_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    pending_d = 1'b0;
                    if (pending_q || PCSrc_E || !stall_D) state_d = S_REQ;
                    else                                  state_d = S_HOLD;
                end else begin
                    // Only the first redirect seen during the wait is kept.
                    if (PCSrc_E && !pending_q) begin
                        pending_d = 1'b1;
                        target_d  = PCBranch_E;
                    end
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == CW'(WAIT_TIMEOUT)) begin
                        state_d    = S_REQ;
                        imem_err_d = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrc_E || !stall_D) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem_req      = 1'b0;
        pc_en_F       = 1'b0;
        PCSrc_F       = 1'b0;
        PCBranch_F    = '0;
        instr_valid_F = 1'b0;
        flush_D       = 1'b0;
        if (reset) begin
            imem_req = 1'b1;
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (PCSrc_E) begin
                        PCSrc_F    = 1'b1;
                        PCBranch_F = PCBranch_E;
                        pc_en_F    = 1'b1;
                        flush_D    = 1'b1;
                    end else begin
                        imem_req = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (pending_q || PCSrc_E) begin
                            PCSrc_F    = 1'b1;
                            PCBranch_F = pending_q ? target_q : PCBranch_E;
                            pc_en_F    = 1'b1;
                            flush_D    = 1'b1;
                        end else begin
                            instr_valid_F = 1'b1;
                            pc_en_F       = !stall_D;
                        end
                    end
                end
                S_HOLD: begin
                    if (PCSrc_E) begin
                        PCSrc_F    = 1'b1;
                        PCBranch_F = PCBranch_E;
                        pc_en_F    = 1'b1;
                        flush_D    = 1'b1;
                    end else begin
                        instr_valid_F = 1'b1;
                        pc_en_F       = !stall_D;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_err = imem_err_q;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redir_q, perf_redir_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_redir_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_redir_q <= perf_redir_d;
        end
    end

    always_comb begin
        perf_fetch_d = perf_fetch_q + {31'd0, instr_valid_F & pc_en_F};
        perf_stall_d = perf_stall_q + {31'd0, (state_q == S_HOLD) & stall_D};
        perf_redir_d = perf_redir_q + {31'd0, PCSrc_F};
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
    assign perf_redir = perf_redir_q;
`else
    assign perf_fetch = '0;
    assign perf_stall = '0;
    assign perf_redir = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, every output checked each cycle
// against a transaction-level model of the fetch handshake.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, PCSrc_E, stall_D, imem_ready, imem_rvalid;
    logic [63:0] PCBranch_E;
    logic        imem_req, pc_en_F, PCSrc_F, instr_valid_F, flush_D, imem_err;
    logic [63:0] PCBranch_F;
    logic [31:0] perf_fetch, perf_stall, perf_redir;

    fetch_ctrl #(.WAIT_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .PCSrc_E(PCSrc_E), .PCBranch_E(PCBranch_E),
        .stall_D(stall_D), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
        .imem_req(imem_req), .pc_en_F(pc_en_F), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
        .instr_valid_F(instr_valid_F), .flush_D(flush_D), .imem_err(imem_err),
        .perf_fetch(perf_fetch), .perf_stall(perf_stall), .perf_redir(perf_redir)
    );

    int tests = 0;
    int failed = 0;

    // Model: an accepted request is outstanding (m_busy) or a delivered instruction is held (m_held).
    bit          m_busy = 0, m_held = 0, m_pend = 0, m_err = 0;
    logic [63:0] m_tgt = '0;
    int          m_waits = 0;
    logic [31:0] m_pf = '0, m_ps = '0, m_pr = '0;

    int          pulses;
    logic [63:0] last_br;
    logic        last_flush, last_valid, last_src, last_err, last_req;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit src, input logic [63:0] br,
                         input bit st, input bit rdy, input bit rv);
        bit e_req, e_en, e_src, e_valid, e_flush, redirect;
        logic [63:0] e_br;
        @(negedge clk);
        reset = r; PCSrc_E = src; PCBranch_E = br; stall_D = st;
        imem_ready = rdy; imem_rvalid = rv;
        #1;
        e_req = 0; e_en = 0; e_src = 0; e_valid = 0; e_flush = 0; e_br = '0; redirect = 0;
        if (r) begin
            e_req = 1;
        end else if (m_busy) begin
            if (rv) begin
                if (m_pend || src) begin
                    redirect = 1;
                    e_br = m_pend ? m_tgt : br;
                end else begin
                    e_valid = 1; e_en = !st;
                end
            end
        end else if (m_held) begin
            if (src) begin
                redirect = 1; e_br = br;
            end else begin
                e_valid = 1; e_en = !st;
            end
        end else begin
            if (src) begin
                redirect = 1; e_br = br;
            end else begin
                e_req = 1;
            end
        end
        if (redirect) begin
            e_src = 1; e_en = 1; e_flush = 1;
        end

        check("imem_req", imem_req, e_req);
        check("pc_en_F", pc_en_F, e_en);
        check("PCSrc_F", PCSrc_F, e_src);
        check("PCBranch_F", PCBranch_F, e_br);
        check("instr_valid_F", instr_valid_F, e_valid);
        check("flush_D", flush_D, e_flush);
        check("imem_err", imem_err, m_err);
`ifdef FETCH_CTRL_PERF_EN
        check("perf_fetch", perf_fetch, m_pf);
        check("perf_stall", perf_stall, m_ps);
        check("perf_redir", perf_redir, m_pr);
`else
        check("perf_fetch", perf_fetch, 64'd0);
        check("perf_stall", perf_stall, 64'd0);
        check("perf_redir", perf_redir, 64'd0);
`endif
        if (pc_en_F === 1'b1) pulses++;
        last_br = PCBranch_F; last_flush = flush_D; last_valid = instr_valid_F;
        last_src = PCSrc_F; last_err = imem_err; last_req = imem_req;

        if (r) begin
            m_busy = 0; m_held = 0; m_pend = 0; m_err = 0; m_tgt = '0; m_waits = 0;
            m_pf = '0; m_ps = '0; m_pr = '0;
        end else begin
            if (e_valid && e_en) m_pf++;
            if (m_held && st)    m_ps++;
            if (e_src)           m_pr++;
            if (m_busy) begin
                if (rv) begin
                    m_busy = 0;
                    m_held = !(m_pend || src) && st;
                    m_pend = 0;
                end else begin
                    if (src && !m_pend) begin
                        m_pend = 1; m_tgt = br;
                    end
                    m_waits++;
                    if (m_waits == 15) begin
                        m_busy = 0; m_err = 1;
                    end
                end
            end else if (m_held) begin
                if (src || !st) m_held = 0;
            end else if (!src && rdy) begin
                m_busy = 1; m_waits = 0;
            end
        end
    endtask

    initial begin
        reset = 1; PCSrc_E = 0; PCBranch_E = '0; stall_D = 0; imem_ready = 1; imem_rvalid = 0;

        // Reset held for five cycles with imem ready.
        repeat (5) cycle(1, 0, 64'd0, 0, 1, 0);

        // Ten back-to-back fetches with a one-cycle memory.
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 64'd0, 0, 1, 0);
            cycle(0, 0, 64'd0, 0, 0, 1);
        end
        check("fetch_pulses", pulses, 10);

        // Late redirect during WAIT; second redirect ignored.
        cycle(0, 0, 64'd0, 0, 1, 0);
        cycle(0, 1, 64'd10016, 0, 0, 0);
        cycle(0, 1, 64'd20032, 0, 0, 0);
        cycle(0, 0, 64'd0, 0, 0, 1);
        check("redir_target", last_br, 64'd10016);
        check("redir_flush", last_flush, 1);
        check("redir_valid", last_valid, 0);

        // Decode stall on response, three HOLD cycles, release.
        cycle(0, 0, 64'd0, 0, 1, 0);
        cycle(0, 0, 64'd0, 1, 0, 1);
        pulses = 0;
        repeat (3) cycle(0, 0, 64'd0, 1, 0, 0);
        check("hold_no_pulse", pulses, 0);
        cycle(0, 0, 64'd0, 0, 0, 0);
        check("hold_release_pulse", pulses, 1);

        // Redirect while holding.
        cycle(0, 0, 64'd0, 0, 1, 0);
        cycle(0, 0, 64'd0, 1, 0, 1);
        cycle(0, 1, 64'h1234, 0, 0, 0);
        check("hold_redir_src", last_src, 1);
        check("hold_redir_flush", last_flush, 1);
        cycle(0, 0, 64'd0, 0, 0, 0);
`ifdef FETCH_CTRL_PERF_EN
        check("perf_fetch_total", perf_fetch, 64'd11);
        check("perf_stall_total", perf_stall, 64'd3);
        check("perf_redir_total", perf_redir, 64'd2);
`endif

        // Timeout: no response for the full wait budget.
        cycle(0, 0, 64'd0, 0, 1, 0);
        repeat (14) cycle(0, 0, 64'd0, 0, 0, 0);
        cycle(0, 0, 64'd0, 0, 0, 0);
        check("err_before_timeout", last_err, 0);
        cycle(0, 0, 64'd0, 0, 0, 0);
        check("err_after_timeout", last_err, 1);
        check("req_after_timeout", last_req, 1);
        repeat (5) cycle(0, 0, 64'd0, 0, 0, 0);
        check("err_sticky", last_err, 1);
        cycle(1, 0, 64'd0, 0, 0, 0);
        cycle(0, 0, 64'd0, 0, 0, 0);
        check("err_cleared", last_err, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(199, 0) == 0,
                  $urandom_range(99, 0) < 15,
                  {$urandom, $urandom},
                  $urandom_range(99, 0) < 40,
                  $urandom_range(99, 0) < 60,
                  $urandom_range(99, 0) < 30);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
